// File: rtl/alu_issuer_pkg.sv
// Shared ALU definitions: operation encoding, issuer FSM states and the
// helper functions used to steer wide operations through a 32-bit ALU.
package aluPkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_ADC = 4'd1,
        OP_SUB = 4'd2,
        OP_SBB = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_NOT = 4'd7
    } aluOpSel;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        CAPTURE = 3'd3,
        RESP    = 3'd4
    } issuerStateSel;

    // High-half op: plain add/sub become their carry-consuming forms so the
    // low-half carry (or borrow) chains into the upper word.
    function automatic aluOpSel hiOpMap(input aluOpSel op);
        aluOpSel mapped;
        case (op)
            OP_ADD:  mapped = OP_ADC;
            OP_SUB:  mapped = OP_SBB;
            default: mapped = op;
        endcase
        return mapped;
    endfunction

    // Arithmetic ops are the ones whose carry becomes architectural.
    function automatic logic isArith(input aluOpSel op);
        logic arith;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: arith = 1'b1;
            default:                        arith = 1'b0;
        endcase
        return arith;
    endfunction

    // Ops that consume the architectural carry on their first pass.
    function automatic logic usesCarryIn(input aluOpSel op);
        logic uses;
        case (op)
            OP_ADC, OP_SBB: uses = 1'b1;
            default:        uses = 1'b0;
        endcase
        return uses;
    endfunction

    // Encodings outside the defined set are executed as ADD.
    function automatic aluOpSel sanitizeOp(input logic [3:0] raw);
        aluOpSel op;
        if (raw <= 4'd7) begin
            op = aluOpSel'(raw);
        end else begin
            op = OP_ADD;
        end
        return op;
    endfunction

endpackage

// File: rtl/alu_issuer_if.sv
// Request, ALU and response channels of the ALU issuer bundled together.
// master = issuer side, slave = environment (issue logic, ALU, consumer).
interface alu_issuer_if;
    import aluPkg::*;

    logic          reqValid;
    logic          reqReady;
    aluOpSel       reqOp;
    logic          reqWide;
    logic [63:0]   reqA;
    logic [63:0]   reqB;

    aluOpSel       aluOp;
    logic          aluStart;
    logic          carryIn;
    logic [31:0]   operandA;
    logic [31:0]   operandB;
    logic          aluDone;
    logic [31:0]   aluResult;
    logic          aluCarry;
    logic          aluOverflow;

    logic          rspValid;
    logic          rspReady;
    logic [63:0]   rspResult;
    logic          rspCarry;
    logic          rspOverflow;
    logic          carryFlag;

    modport master (
        input  reqValid, reqOp, reqWide, reqA, reqB,
        input  aluDone, aluResult, aluCarry, aluOverflow,
        input  rspReady,
        output reqReady, aluOp, aluStart, carryIn, operandA, operandB,
        output rspValid, rspResult, rspCarry, rspOverflow, carryFlag
    );

    modport slave (
        output reqValid, reqOp, reqWide, reqA, reqB,
        output aluDone, aluResult, aluCarry, aluOverflow,
        output rspReady,
        input  reqReady, aluOp, aluStart, carryIn, operandA, operandB,
        input  rspValid, rspResult, rspCarry, rspOverflow, carryFlag
    );

endinterface

// File: rtl/alu_issuer.sv
// Execute-stage ALU issuer: one operation at a time, 64-bit ops split into
// a low and high 32-bit pass with carry chaining, owns the carry flag.
module alu_issuer
    import aluPkg::*;
(
    input  logic         clk,
    input  logic         reset,
    alu_issuer_if.master bus
);

    issuerStateSel state_r;
    issuerStateSel nextState_s;

    aluOpSel       opLatched_r;
    logic          wide_r;
    logic          halfHi_r;
    logic [31:0]   aHi_r;
    logic [31:0]   bHi_r;

    aluOpSel       aluOp_r;
    logic          aluStart_r;
    logic          carryIn_r;
    logic [31:0]   operandA_r;
    logic [31:0]   operandB_r;
    logic          reqReady_r;
    logic          rspValid_r;
    logic [63:0]   rspResult_r;
    logic          rspCarry_r;
    logic          rspOverflow_r;
    logic          carryFlag_r;

    logic          acceptEn_s;
    logic          captureEn_s;
    logic          reissueEn_s;
    logic          rspFire_s;
    aluOpSel       acceptOp_s;

    assign acceptOp_s = sanitizeOp(bus.reqOp);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= nextState_s;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState_s = state_r;
        case (state_r)
            IDLE:    nextState_s = bus.reqValid ? ISSUE : IDLE;
            ISSUE:   nextState_s = bus.aluDone ? CAPTURE : WAIT;
            WAIT:    nextState_s = bus.aluDone ? CAPTURE : WAIT;
            CAPTURE: nextState_s = (wide_r && !halfHi_r) ? ISSUE : RESP;
            RESP:    nextState_s = bus.rspReady ? IDLE : RESP;
            default: nextState_s = IDLE;
        endcase
    end

    // Per-state action enables feeding the datapath registers.
    always_comb begin
        acceptEn_s  = 1'b0;
        captureEn_s = 1'b0;
        reissueEn_s = 1'b0;
        rspFire_s   = 1'b0;
        case (state_r)
            IDLE:    acceptEn_s = bus.reqValid;
            CAPTURE: begin
                captureEn_s = 1'b1;
                reissueEn_s = wide_r && !halfHi_r;
            end
            RESP:    rspFire_s = bus.rspReady;
            default: acceptEn_s = 1'b0;
        endcase
    end

    // Handshake strobes registered from the upcoming state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            aluStart_r <= 1'b0;
            reqReady_r <= 1'b1;
            rspValid_r <= 1'b0;
        end else begin
            aluStart_r <= (nextState_s == ISSUE);
            reqReady_r <= (nextState_s == IDLE);
            rspValid_r <= (nextState_s == RESP);
        end
    end

    // Request latch, ALU drive, result capture and architectural carry.
    always_ff @(posedge clk) begin
        if (reset) begin
            opLatched_r   <= OP_ADD;
            wide_r        <= 1'b0;
            halfHi_r      <= 1'b0;
            aHi_r         <= 32'd0;
            bHi_r         <= 32'd0;
            aluOp_r       <= OP_ADD;
            carryIn_r     <= 1'b0;
            operandA_r    <= 32'd0;
            operandB_r    <= 32'd0;
            rspResult_r   <= 64'd0;
            rspCarry_r    <= 1'b0;
            rspOverflow_r <= 1'b0;
            carryFlag_r   <= 1'b0;
        end else begin
            if (acceptEn_s) begin
                opLatched_r <= acceptOp_s;
                wide_r      <= bus.reqWide;
                halfHi_r    <= 1'b0;
                aHi_r       <= bus.reqA[63:32];
                bHi_r       <= bus.reqB[63:32];
                aluOp_r     <= acceptOp_s;
                operandA_r  <= bus.reqA[31:0];
                operandB_r  <= bus.reqB[31:0];
                carryIn_r   <= usesCarryIn(acceptOp_s) ? carryFlag_r : 1'b0;
            end else if (reissueEn_s) begin
                // Low carry is taken straight from the ALU flag being captured.
                halfHi_r    <= 1'b1;
                aluOp_r     <= hiOpMap(opLatched_r);
                operandA_r  <= aHi_r;
                operandB_r  <= bHi_r;
                carryIn_r   <= bus.aluCarry;
            end
            if (captureEn_s) begin
                if (halfHi_r) begin
                    rspResult_r[63:32] <= bus.aluResult;
                end else begin
                    rspResult_r <= {32'd0, bus.aluResult};
                end
                rspCarry_r    <= bus.aluCarry;
                rspOverflow_r <= bus.aluOverflow;
            end
            if (rspFire_s) begin
                carryFlag_r <= isArith(opLatched_r) ? rspCarry_r : 1'b0;
            end
        end
    end

    assign bus.reqReady    = reqReady_r;
    assign bus.aluOp       = aluOp_r;
    assign bus.aluStart    = aluStart_r;
    assign bus.carryIn     = carryIn_r;
    assign bus.operandA    = operandA_r;
    assign bus.operandB    = operandB_r;
    assign bus.rspValid    = rspValid_r;
    assign bus.rspResult   = rspResult_r;
    assign bus.rspCarry    = rspCarry_r;
    assign bus.rspOverflow = rspOverflow_r;
    assign bus.carryFlag   = carryFlag_r;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed testbench for alu_issuer with a behavioural latency-configurable
// 32-bit ALU and a scoreboard queue of expected responses.
module tb_alu_issuer;
    import aluPkg::*;

    typedef struct {
        logic [63:0] result;
        logic        carry;
        logic        overflow;
    } sbEntry;

    logic   clk;
    logic   reset;
    int     errors;
    int     checks;
    int     aluLatency;
    int     stubCnt;
    int     startCount;
    logic   modelCf;
    sbEntry sbQ[$];

    alu_issuer_if bus ();

    alu_issuer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU: returns {carry, overflow, result}.
    function automatic logic [33:0] aluModel(input aluOpSel op, input logic [31:0] a,
                                             input logic [31:0] b, input logic cin);
        logic [32:0] s;
        logic [31:0] bb;
        logic        v;
        bb = b;
        v  = 1'b0;
        case (op)
            OP_ADD:  s = {1'b0, a} + {1'b0, b};
            OP_ADC:  s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
            OP_SUB:  begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 33'd1; end
            OP_SBB:  begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + {32'd0, cin}; end
            OP_AND:  s = {1'b0, a & b};
            OP_OR:   s = {1'b0, a | b};
            OP_XOR:  s = {1'b0, a ^ b};
            OP_NOT:  s = {1'b0, ~a};
            default: s = 33'd0;
        endcase
        if (isArith(op)) v = (a[31] == bb[31]) && (s[31] != a[31]);
        return {s[32], v, s[31:0]};
    endfunction

    // ALU stub: aluDone arrives aluLatency-1 cycles after aluStart
    // (same cycle when latency is 1); results register on the aluDone edge.
    always_comb bus.aluDone = (aluLatency <= 1) ? bus.aluStart : (stubCnt == 1);

    always_ff @(posedge clk) begin
        logic [33:0] r;
        if (reset) begin
            stubCnt         <= 0;
            bus.aluResult   <= 32'd0;
            bus.aluCarry    <= 1'b0;
            bus.aluOverflow <= 1'b0;
        end else begin
            if (bus.aluStart && aluLatency > 1) stubCnt <= aluLatency - 1;
            else if (stubCnt != 0) stubCnt <= stubCnt - 1;
            if (bus.aluDone) begin
                r = aluModel(bus.aluOp, bus.operandA, bus.operandB, bus.carryIn);
                bus.aluCarry    <= r[33];
                bus.aluOverflow <= r[32];
                bus.aluResult   <= r[31:0];
            end
        end
    end

    // Counts aluStart pulses for the pass-count checks.
    always @(posedge clk) begin
        if (bus.aluStart === 1'b1) startCount <= startCount + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doOp(input string tag, input aluOpSel op, input logic wide,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] expRes, input logic expC, input logic expV,
                        input logic expCf, input int expLat, input int holdCyc);
        sbEntry e;
        int     lat;
        int     startBase;
        check({tag, ".reqReady"}, {63'd0, bus.reqReady}, 64'd1);
        bus.reqValid = 1'b1;
        bus.reqOp    = op;
        bus.reqWide  = wide;
        bus.reqA     = a;
        bus.reqB     = b;
        e.result     = expRes;
        e.carry      = expC;
        e.overflow   = expV;
        sbQ.push_back(e);
        startBase = startCount;
        tick();
        bus.reqValid = 1'b0;
        lat = 1;
        while (bus.rspValid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(expLat));
        check({tag, ".starts"}, 64'(startCount - startBase), wide ? 64'd2 : 64'd1);
        if (sbQ.size() > 0) e = sbQ.pop_front();
        check({tag, ".result"}, bus.rspResult, e.result);
        check({tag, ".carry"}, {63'd0, bus.rspCarry}, {63'd0, e.carry});
        check({tag, ".overflow"}, {63'd0, bus.rspOverflow}, {63'd0, e.overflow});
        for (int i = 0; i < holdCyc; i++) begin
            tick();
            check({tag, ".holdValid"}, {63'd0, bus.rspValid}, 64'd1);
            check({tag, ".holdResult"}, bus.rspResult, e.result);
            check({tag, ".holdCarry"}, {63'd0, bus.rspCarry}, {63'd0, e.carry});
            check({tag, ".holdReqReady"}, {63'd0, bus.reqReady}, 64'd0);
            check({tag, ".holdCarryFlag"}, {63'd0, bus.carryFlag}, {63'd0, modelCf});
            check({tag, ".holdStarts"}, 64'(startCount - startBase), wide ? 64'd2 : 64'd1);
        end
        bus.rspReady = 1'b1;
        tick();
        bus.rspReady = 1'b0;
        modelCf = expCf;
        check({tag, ".rspValidDrop"}, {63'd0, bus.rspValid}, 64'd0);
        check({tag, ".carryFlag"}, {63'd0, bus.carryFlag}, {63'd0, expCf});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        errors       = 0;
        checks       = 0;
        startCount   = 0;
        modelCf      = 1'b0;
        aluLatency   = 1;
        reset        = 1'b1;
        bus.reqValid = 1'b0;
        bus.reqOp    = OP_ADD;
        bus.reqWide  = 1'b0;
        bus.reqA     = 64'd0;
        bus.reqB     = 64'd0;
        bus.rspReady = 1'b0;
        tick();
        tick();
        check("rst.reqReady", {63'd0, bus.reqReady}, 64'd1);
        check("rst.aluStart", {63'd0, bus.aluStart}, 64'd0);
        check("rst.rspValid", {63'd0, bus.rspValid}, 64'd0);
        check("rst.carryFlag", {63'd0, bus.carryFlag}, 64'd0);
        check("rst.rspCarry", {63'd0, bus.rspCarry}, 64'd0);
        check("rst.rspOverflow", {63'd0, bus.rspOverflow}, 64'd0);
        check("rst.rspResult", bus.rspResult, 64'd0);
        check("rst.operandA", {32'd0, bus.operandA}, 64'd0);
        check("rst.operandB", {32'd0, bus.operandB}, 64'd0);
        check("rst.aluOp", {60'd0, bus.aluOp}, {60'd0, OP_ADD});
        check("rst.carryIn", {63'd0, bus.carryIn}, 64'd0);
        reset = 1'b0;
        tick();

        // Zero-latency ALU.
        doOp("wideAdd", OP_ADD, 1'b1, 64'h00000000_FFFFFFFF, 64'd1,
             64'h00000001_00000000, 1'b0, 1'b0, 1'b0, 5, 0);
        doOp("wideSub", OP_SUB, 1'b1, 64'd0, 64'd1,
             64'hFFFFFFFF_FFFFFFFF, 1'b0, 1'b0, 1'b0, 5, 0);
        doOp("setCarry", OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'd1,
             64'd0, 1'b1, 1'b0, 1'b1, 3, 0);
        doOp("adcCarry", OP_ADC, 1'b0, 64'd5, 64'd7,
             64'h00000000_0000000D, 1'b0, 1'b0, 1'b0, 3, 0);
        doOp("sgnOvf", OP_ADD, 1'b0, 64'h00000000_7FFFFFFF, 64'd1,
             64'h00000000_80000000, 1'b0, 1'b1, 1'b0, 3, 0);
        doOp("badOp", aluOpSel'(4'hF), 1'b0, 64'd5, 64'd6,
             64'h00000000_0000000B, 1'b0, 1'b0, 1'b0, 3, 0);
        doOp("setCarry2", OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'd1,
             64'd0, 1'b1, 1'b0, 1'b1, 3, 0);
        doOp("narrowAnd", OP_AND, 1'b0, 64'hDEADBEEF_0000FF00, 64'hFFFFFFFF_00000FF0,
             64'h00000000_00000F00, 1'b0, 1'b0, 1'b0, 3, 0);

        // Slow ALU: aluDone on the third cycle of each pass.
        aluLatency = 3;
        doOp("slowCarry", OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'd1,
             64'd0, 1'b1, 1'b0, 1'b1, 5, 0);
        doOp("slowXor", OP_XOR, 1'b1, 64'hF0F0F0F0_0F0F0F0F, 64'hFFFFFFFF_FFFFFFFF,
             64'h0F0F0F0F_F0F0F0F0, 1'b0, 1'b0, 1'b0, 9, 4);
        doOp("slowCarry2", OP_ADD, 1'b0, 64'h00000000_FFFFFFFF, 64'd1,
             64'd0, 1'b1, 1'b0, 1'b1, 5, 0);

        // Reset while a wide op waits on the ALU.
        check("rstMid.reqReady", {63'd0, bus.reqReady}, 64'd1);
        bus.reqValid = 1'b1;
        bus.reqOp    = OP_ADD;
        bus.reqWide  = 1'b1;
        bus.reqA     = 64'h12345678_9ABCDEF0;
        bus.reqB     = 64'h11111111_22222222;
        tick();
        bus.reqValid = 1'b0;
        check("rstMid.issue", {63'd0, bus.aluStart}, 64'd1);
        tick();
        check("rstMid.wait", {63'd0, bus.aluStart}, 64'd0);
        check("rstMid.cfBefore", {63'd0, bus.carryFlag}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        modelCf = 1'b0;
        check("rstMid.aluStart", {63'd0, bus.aluStart}, 64'd0);
        check("rstMid.rspValid", {63'd0, bus.rspValid}, 64'd0);
        check("rstMid.carryFlag", {63'd0, bus.carryFlag}, 64'd0);
        check("rstMid.reqReady", {63'd0, bus.reqReady}, 64'd1);
        check("rstMid.operandA", {32'd0, bus.operandA}, 64'd0);
        for (int i = 0; i < 5; i++) tick();
        check("rstMid.noRsp", {63'd0, bus.rspValid}, 64'd0);
        aluLatency = 1;
        doOp("afterRst", OP_ADD, 1'b0, 64'd2, 64'd3,
             64'd5, 1'b0, 1'b0, 1'b0, 3, 0);

        check("sb.empty", 64'(sbQ.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
